// File: rtl/shift_reg_piso_tx.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_tx
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted through a
//   valid/ready handshake and shifted out one bit per clock on sdo. Frames can
//   run back to back with no idle cycle between them, so a downstream SIPO sees
//   a continuous bit stream.
//
//   Handshake: a word transfers on the rising edge where load_valid and
//   load_ready are both high. load_ready is high in IDLE and during the last
//   bit of a frame. A load_valid that arrives while load_ready is low is
//   ignored; it is not queued, so the source must hold it until load_ready.
//
//   Optional build macro: PISO_TX_PARITY_EN
//     Defined   - an even-parity bit (XOR of the data bits) follows the last
//                 data bit, so a frame is WIDTH+1 bits long.
//     Undefined - frames carry only the WIDTH data bits.
//
// Parameters
//   WIDTH      data word width, 2..16
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   load_data   parallel word to transmit
//   load_valid  load_data is valid this cycle
//   load_ready  a word can be accepted this cycle (combinational)
//   sdo         serial data out (registered)
//   sdo_valid   sdo carries a frame bit this cycle
//   busy        frame in progress (FSM in SHIFT)
//   done        high while the last bit of a frame is on sdo
//   state_dbg   current FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module shift_reg_piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done,
  output logic             state_dbg
);

`ifdef PISO_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int             CW   = $clog2(NBITS);
  localparam logic [CW-1:0]  LAST = CW'(NBITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             sdo_d, valid_d, busy_d, done_d;
  logic             last_bit, load_fire;
  logic             first_bit, shreg_bit, next_bit;
  logic [WIDTH-1:0] load_rest, shreg_shift;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // cnt_q always matches the index of the bit currently on sdo.
  assign cnt_inc    = cnt_q + CW'(1);
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign load_fire  = load_valid && load_ready;
  assign state_dbg  = state_q;

  // The first bit goes straight from load_data into the sdo flop, so the
  // shift register only needs to hold the bits that are still to come.
  always_comb begin
    if (MSB_FIRST != 0) begin
      first_bit   = load_data[WIDTH-1];
      load_rest   = load_data << 1;
      shreg_bit   = shreg_q[WIDTH-1];
      shreg_shift = shreg_q << 1;
    end else begin
      first_bit   = load_data[0];
      load_rest   = load_data >> 1;
      shreg_bit   = shreg_q[0];
      shreg_shift = shreg_q >> 1;
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Bit index WIDTH is the appended parity bit.
  assign next_bit = (cnt_inc == CW'(WIDTH)) ? par_q : shreg_bit;
  assign par_d    = load_fire ? ^load_data : par_q;
`else
  assign next_bit = shreg_bit;
`endif

  // FSM process 1: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM process 2: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_fire) state_d = SHIFT;
      SHIFT:   if (last_bit && !load_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM process 3: next values of the registered outputs and datapath
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sdo_d   = sdo;
    valid_d = sdo_valid;
    busy_d  = busy;
    done_d  = done;
    if (load_fire) begin
      // Covers both a load from IDLE and a reload during the last bit.
      shreg_d = load_rest;
      cnt_d   = '0;
      sdo_d   = first_bit;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (last_bit) begin
      cnt_d   = '0;
      sdo_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (state_q == SHIFT) begin
      shreg_d = shreg_shift;
      cnt_d   = cnt_inc;
      sdo_d   = next_bit;
      done_d  = (cnt_inc == LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      sdo       <= sdo_d;
      sdo_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef PISO_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_piso_tx
//   Bench for shift_reg_piso_tx (WIDTH=4). Instance m_dut is MSB-first,
//   instance l_dut is LSB-first. Every accepted word pushes its expected
//   {sdo, done} sequence onto a per-instance queue; a monitor on the falling
//   edge pops one entry per sdo_valid cycle and checks the idle outputs
//   otherwise. Expected bit orders come from constant tables (and a small
//   bit-reverse/parity model for random words).
// -----------------------------------------------------------------------------
module tb_shift_reg_piso_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [3:0] m_data = '0, l_data = '0;
  logic       m_valid = 1'b0, l_valid = 1'b0;
  logic       m_ready, m_sdo, m_sdo_valid, m_busy, m_done, m_state;
  logic       l_ready, l_sdo, l_sdo_valid, l_busy, l_done, l_state;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];
  logic [3:0] sipo_q;

  typedef struct {
    logic [3:0] data;
    logic [3:0] ser;   // expected transmit order, ser[3] leaves first
    logic       par;
  } vec_t;

  vec_t vm[8];
  vec_t vl[4];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1)) m_dut (
    .clk(clk), .reset(reset), .load_data(m_data), .load_valid(m_valid),
    .load_ready(m_ready), .sdo(m_sdo), .sdo_valid(m_sdo_valid),
    .busy(m_busy), .done(m_done), .state_dbg(m_state)
  );

  shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(0)) l_dut (
    .clk(clk), .reset(reset), .load_data(l_data), .load_valid(l_valid),
    .load_ready(l_ready), .sdo(l_sdo), .sdo_valid(l_sdo_valid),
    .busy(l_busy), .done(l_done), .state_dbg(l_state)
  );

  // Downstream 4-bit SIPO fed by the MSB-first transmitter.
  always @(posedge clk or posedge reset) begin
    if (reset)            sipo_q <= '0;
    else if (m_sdo_valid) sipo_q <= {sipo_q[2:0], m_sdo};
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] d);
    return {d[0], d[1], d[2], d[3]};
  endfunction

  task automatic push_frame(input bit lsb, input logic [3:0] ser, input logic par);
    logic [1:0] e;
    logic       last;
    for (int i = 3; i >= 0; i--) begin
`ifdef PISO_TX_PARITY_EN
      last = 1'b0;
`else
      last = (i == 0);
`endif
      e = {ser[i], last};
      if (lsb) exp_l.push_back(e); else exp_m.push_back(e);
    end
`ifdef PISO_TX_PARITY_EN
    e = {par, 1'b1};
    if (lsb) exp_l.push_back(e); else exp_m.push_back(e);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic send(input bit lsb, input logic [3:0] data, input logic [3:0] ser,
                      input logic par);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (lsb) begin l_data = data; l_valid = 1'b1; end
    else     begin m_data = data; m_valid = 1'b1; end
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if ((lsb ? l_ready : m_ready) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: load_ready got 0 expected 1 (data %0h)", data);
    end else begin
      push_frame(lsb, ser, par);
      @(posedge clk); #1;
    end
    if (lsb) l_valid = 1'b0; else m_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit lsb);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 64 && !idle; n++) begin
      @(negedge clk);
      if (lsb) idle = (exp_l.size() == 0) && !l_sdo_valid;
      else     idle = (exp_m.size() == 0) && !m_sdo_valid;
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle_timeout: frame still active expected idle (lsb=%0d)", lsb);
    end
    chk(lsb ? "l_state_idle" : "m_state_idle", lsb ? l_state : m_state, 0);
    chk(lsb ? "l_queue_empty" : "m_queue_empty", lsb ? exp_l.size() : exp_m.size(), 0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      if (m_sdo_valid) begin
        if (exp_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL m_unexpected_bit: got sdo=%0b expected no frame bit", m_sdo);
        end else begin
          e = exp_m.pop_front();
          chk("m_sdo", m_sdo, e[1]);
          chk("m_done", m_done, e[0]);
          chk("m_ready", m_ready, e[0]);
          chk("m_busy", m_busy, 1);
        end
      end else begin
        chk("m_idle_sdo", m_sdo, 0);
        chk("m_idle_done", m_done, 0);
        chk("m_idle_busy", m_busy, 0);
        chk("m_idle_ready", m_ready, 1);
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      if (l_sdo_valid) begin
        if (exp_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL l_unexpected_bit: got sdo=%0b expected no frame bit", l_sdo);
        end else begin
          e = exp_l.pop_front();
          chk("l_sdo", l_sdo, e[1]);
          chk("l_done", l_done, e[0]);
          chk("l_ready", l_ready, e[0]);
          chk("l_busy", l_busy, 1);
        end
      end else begin
        chk("l_idle_sdo", l_sdo, 0);
        chk("l_idle_done", l_done, 0);
        chk("l_idle_busy", l_busy, 0);
        chk("l_idle_ready", l_ready, 1);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] r;

    vm[0] = '{4'b1011, 4'b1011, 1'b1};
    vm[1] = '{4'hA,    4'hA,    1'b0};
    vm[2] = '{4'h5,    4'h5,    1'b0};
    vm[3] = '{4'hC,    4'hC,    1'b0};
    vm[4] = '{4'b0111, 4'b0111, 1'b1};
    vm[5] = '{4'b0110, 4'b0110, 1'b0};
    vm[6] = '{4'hF,    4'hF,    1'b0};
    vm[7] = '{4'h0,    4'h0,    1'b0};
    vl[0] = '{4'b0001, 4'b1000, 1'b1};
    vl[1] = '{4'b1011, 4'b1101, 1'b1};
    vl[2] = '{4'hC,    4'h3,    1'b0};
    vl[3] = '{4'h6,    4'h6,    1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sdo", m_sdo, 0);
    chk("rst_sdo_valid", m_sdo_valid, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_ready", m_ready, 1);
    chk("rst_state", m_state, 0);
    #1 reset = 1'b0;

    // Single frame into the SIPO
    send(1'b0, 4'b1011, 4'b1011, 1'b1);
    wait_idle(1'b0);
`ifdef PISO_TX_PARITY_EN
    chk("sipo_q", sipo_q, 4'b0111);
`else
    chk("sipo_q", sipo_q, 4'b1011);
`endif

    // Table-driven frames, both bit orders
    for (int i = 0; i < 8; i++) begin
      send(1'b0, vm[i].data, vm[i].ser, vm[i].par);
      wait_idle(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, vl[i].data, vl[i].ser, vl[i].par);
      wait_idle(1'b1);
    end

    // Random words
    for (int i = 0; i < 6; i++) begin
      r = 4'($urandom_range(0, 15));
      send(1'b0, r, r, ^r);
      wait_idle(1'b0);
      r = 4'($urandom_range(0, 15));
      send(1'b1, r, rev4(r), ^r);
      wait_idle(1'b1);
    end

    // Back-to-back: 4'hA then 4'h5 held through the last-bit cycle
    @(posedge clk); #1;
    m_data = 4'hA; m_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready_idle", m_ready, 1);
    push_frame(1'b0, 4'hA, 1'b0);
    push_frame(1'b0, 4'h5, 1'b0);
    @(posedge clk); #1;
    m_data = 4'h5;
`ifdef PISO_TX_PARITY_EN
    for (int k = 0; k < 5; k++) begin
`else
    for (int k = 0; k < 4; k++) begin
`endif
      @(negedge clk);
      chk("b2b_valid_a", m_sdo_valid, 1);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
`ifdef PISO_TX_PARITY_EN
    for (int k = 0; k < 5; k++) begin
`else
    for (int k = 0; k < 4; k++) begin
`endif
      @(negedge clk);
      chk("b2b_valid_5", m_sdo_valid, 1);
    end
    wait_idle(1'b0);

    // Busy rejection: 4'h3 pulsed in frame cycle 2 is never sent
    send(1'b0, 4'hC, 4'hC, 1'b0);
    @(posedge clk); #1;
    m_data = 4'h3; m_valid = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    wait_idle(1'b0);
    repeat (3) @(negedge clk);
    chk("reject_state", m_state, 0);

    // Reset mid-frame, then a clean frame
    send(1'b0, 4'hF, 4'hF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_sdo", m_sdo, 0);
    chk("midrst_valid", m_sdo_valid, 0);
    chk("midrst_busy", m_busy, 0);
    chk("midrst_ready", m_ready, 1);
    exp_m.delete();
    @(posedge clk); #1 reset = 1'b0;
    send(1'b0, 4'h9, 4'h9, 1'b0);
    wait_idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
